// File: rtl/sensor_conditioner.sv
// Gate sensor front end: synchronises and debounces the entry/exit beams, recognises
// complete vehicle passes and issues one-cycle pass pulses, never two in one cycle.
module sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES  = 4,
  parameter int MAX_BLOCK_CYCLES = 64,
  parameter int CNT_W            = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_entry,
  input  logic       raw_exit,
  input  logic [1:0] raw_exit_loc,
  output logic       entry_sensor,
  output logic       exit_sensor,
  output logic [1:0] exit_location,
  output logic       entry_fault,
  output logic       exit_fault
);

  typedef enum logic [1:0] {IDLE, BLOCKED, FAULT} lane_state_t;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(MAX_BLOCK_CYCLES - 1);

  // Lane index 0 is the entry gate, 1 is the exit gate.
  logic [1:0] beam_s1, beam_s2;
  logic [1:0] loc_s1, loc_s2;
  logic [1:0] done, blk_start, fault;
  logic [1:0] req, pend, issue;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beam_s1 <= '0;
      beam_s2 <= '0;
      loc_s1  <= '0;
      loc_s2  <= '0;
    end else begin
      beam_s1 <= {raw_exit, raw_entry};
      beam_s2 <= beam_s1;
      loc_s1  <= raw_exit_loc;
      loc_s2  <= loc_s1;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic              s, db, db_next;
    logic [CNT_W-1:0]  db_cnt, blk_cnt;
    lane_state_t       state;

    assign s = beam_s2[g];

    // The lane FSM follows the debounced level as it changes, so it reacts on the
    // same edge the debouncer accepts a new level.
    always_comb begin
      db_next = db;
      if (s != db && db_cnt == DB_LAST) db_next = s;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        db      <= 1'b0;
        db_cnt  <= '0;
        blk_cnt <= '0;
        state   <= IDLE;
      end else begin
        db <= db_next;
        if (s == db || db_cnt == DB_LAST) db_cnt <= '0;
        else                              db_cnt <= db_cnt + 1'b1;

        case (state)
          IDLE: begin
            if (db_next) begin
              state   <= BLOCKED;
              blk_cnt <= '0;
            end
          end
          BLOCKED: begin
            if (!db_next)                state   <= IDLE;
            else if (blk_cnt == BLK_LAST) state   <= FAULT;
            else                         blk_cnt <= blk_cnt + 1'b1;
          end
          FAULT: begin
            if (!db_next) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end

    assign done[g]      = (state == BLOCKED) && !db_next;
    assign blk_start[g] = (state == IDLE) && db_next;
    assign fault[g]     = (state == FAULT);
  end

  assign entry_fault = fault[0];
  assign exit_fault  = fault[1];

  // Older pending pulses win; among fresh requests entry goes first.
  always_comb begin
    issue = '0;
    if      (pend[1]) issue[1] = 1'b1;
    else if (pend[0]) issue[0] = 1'b1;
    else if (req[0])  issue[0] = 1'b1;
    else if (req[1])  issue[1] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req           <= '0;
      pend          <= '0;
      entry_sensor  <= 1'b0;
      exit_sensor   <= 1'b0;
      exit_location <= '0;
    end else begin
      req          <= done;
      pend         <= (pend | req) & ~issue;
      entry_sensor <= issue[0];
      exit_sensor  <= issue[1];
      if (blk_start[1]) exit_location <= loc_s2;
    end
  end

endmodule

// File: tb/tb_sensor_conditioner.sv
// Bench for sensor_conditioner: directed and random beam traffic checked against a
// pass-level model built from debounce windows, block durations and a pulse queue.
module tb_sensor_conditioner;

  localparam int DB  = 4;
  localparam int MAX = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       raw_entry, raw_exit;
  logic [1:0] raw_exit_loc;
  logic       entry_sensor, exit_sensor, entry_fault, exit_fault;
  logic [1:0] exit_location;
  logic [5:0] act;

  int vectors = 0;
  int miscompares = 0;

  sensor_conditioner #(
    .DEBOUNCE_CYCLES (DB),
    .MAX_BLOCK_CYCLES(MAX),
    .CNT_W           (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .raw_entry    (raw_entry),
    .raw_exit     (raw_exit),
    .raw_exit_loc (raw_exit_loc),
    .entry_sensor (entry_sensor),
    .exit_sensor  (exit_sensor),
    .exit_location(exit_location),
    .entry_fault  (entry_fault),
    .exit_fault   (exit_fault)
  );

  always #5 clk = ~clk;

  assign act = {entry_sensor, exit_sensor, exit_location, entry_fault, exit_fault};

  // Reference model state: raw sample history per lane (bit0 = newest), debounced
  // level, start edge of the current block, and a FIFO of completed passes.
  logic [5:0] hist [2];
  bit         mdb [2];
  bit         in_blk [2];
  bit         faulted [2];
  int         blk_since [2];
  logic [1:0] locq [3];
  int         pend_q [$];
  bit         exp_entry, exp_exit;
  logic [1:0] exp_loc;
  int         edge_n;
  int         exp_entry_total;

  function automatic logic [5:0] exp_vec();
    return {exp_entry, exp_exit, exp_loc, faulted[0], faulted[1]};
  endfunction

  task automatic model_clear();
    for (int l = 0; l < 2; l++) begin
      hist[l] = '0; mdb[l] = 0; in_blk[l] = 0; faulted[l] = 0; blk_since[l] = 0;
    end
    for (int i = 0; i < 3; i++) locq[i] = '0;
    pend_q.delete();
    exp_entry = 0; exp_exit = 0; exp_loc = '0; edge_n = 0;
  endtask

  task automatic model_step();
    logic [1:0] raws;
    raws = {raw_exit, raw_entry};
    for (int l = 0; l < 2; l++) hist[l] = {hist[l][4:0], raws[l]};
    locq[2] = locq[1]; locq[1] = locq[0]; locq[0] = raw_exit_loc;
    exp_entry = 0; exp_exit = 0;
    if (pend_q.size() > 0) begin
      if (pend_q.pop_front() == 0) begin exp_entry = 1; exp_entry_total++; end
      else exp_exit = 1;
    end
    // A level is accepted once the synchronised beam (2 samples late) has shown it DB times in a row.
    for (int l = 0; l < 2; l++) begin
      if (!mdb[l] && hist[l][5:2] == 4'hF) begin
        mdb[l] = 1; in_blk[l] = 1; blk_since[l] = edge_n;
        if (l == 1) exp_loc = locq[2];
      end else if (mdb[l] && hist[l][5:2] == 4'h0) begin
        mdb[l] = 0;
        if (in_blk[l]) pend_q.push_back(l);
        in_blk[l] = 0; faulted[l] = 0;
      end else if (in_blk[l] && edge_n - blk_since[l] == MAX) begin
        in_blk[l] = 0; faulted[l] = 1;
      end
    end
    edge_n++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_clear();
    else       model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if (act !== 6'b0) begin
        miscompares++;
        $display("FAIL reset_hold cycle %0d: dut=%b required=%b", c, act, 6'b0);
      end
    end
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      vectors++;
      if (act !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_release cycle %0d: dut=%b model=%b", c, act, exp_vec());
      end
    end
  endtask

  task automatic test_clean_entry();
    int pulses, pulse_at, exits;
    pulses = 0; pulse_at = -1; exits = 0;
    for (int c = 0; c < 30; c++) begin
      raw_entry = (c < 10);
      tick();
      vectors++;
      if (act !== exp_vec()) begin
        miscompares++;
        $display("FAIL clean_entry cycle %0d: dut=%b model=%b", c, act, exp_vec());
      end
      if (entry_sensor) begin pulses++; pulse_at = c; end
      if (exit_sensor) exits++;
    end
    vectors++;
    if (pulses != 1 || pulse_at != 16) begin
      miscompares++;
      $display("FAIL clean_entry_timing: pulses=%0d at=%0d required 1 at 16", pulses, pulse_at);
    end
    vectors++;
    if (exits != 0) begin
      miscompares++;
      $display("FAIL clean_entry_no_exit: exit pulses=%0d required 0", exits);
    end
  endtask

  task automatic test_glitch();
    int pulses, faults;
    pulses = 0; faults = 0;
    for (int c = 0; c < 50; c++) begin
      raw_entry = (c < 40) && (c % 8 < 2);
      tick();
      vectors++;
      if (act !== exp_vec()) begin
        miscompares++;
        $display("FAIL glitch cycle %0d: dut=%b model=%b", c, act, exp_vec());
      end
      if (entry_sensor) pulses++;
      if (entry_fault) faults++;
    end
    vectors++;
    if (pulses != 0 || faults != 0) begin
      miscompares++;
      $display("FAIL glitch_reject: pulses=%0d fault cycles=%0d required 0/0", pulses, faults);
    end
  endtask

  task automatic test_exit_loc();
    int pulses;
    logic [1:0] loc_at_pulse;
    pulses = 0; loc_at_pulse = 2'b00;
    for (int c = 0; c < 30; c++) begin
      raw_exit     = (c < 10);
      raw_exit_loc = (c < 10) ? 2'b10 : 2'b01;
      tick();
      vectors++;
      if (act !== exp_vec()) begin
        miscompares++;
        $display("FAIL exit_loc cycle %0d: dut=%b model=%b", c, act, exp_vec());
      end
      if (exit_sensor) begin pulses++; loc_at_pulse = exit_location; end
    end
    vectors++;
    if (pulses != 1 || loc_at_pulse !== 2'b10) begin
      miscompares++;
      $display("FAIL exit_loc_pulse: pulses=%0d loc=%b required 1 with 10", pulses, loc_at_pulse);
    end
    vectors++;
    if (exit_location !== 2'b10) begin
      miscompares++;
      $display("FAIL exit_loc_hold: loc=%b required 10", exit_location);
    end
  endtask

  task automatic test_simultaneous();
    int te, tx, overlap;
    te = -1; tx = -1; overlap = 0;
    for (int c = 0; c < 32; c++) begin
      raw_entry    = (c < 10);
      raw_exit     = (c < 10);
      raw_exit_loc = 2'b11;
      tick();
      vectors++;
      if (act !== exp_vec()) begin
        miscompares++;
        $display("FAIL simultaneous cycle %0d: dut=%b model=%b", c, act, exp_vec());
      end
      if (entry_sensor) te = c;
      if (exit_sensor) tx = c;
      if (entry_sensor && exit_sensor) overlap++;
    end
    vectors++;
    if (te != 16 || tx != 17 || overlap != 0) begin
      miscompares++;
      $display("FAIL simultaneous_order: entry@%0d exit@%0d overlap=%0d required 16/17/0", te, tx, overlap);
    end
  endtask

  task automatic test_stuck();
    int rise, fall, pulses;
    rise = -1; fall = -1; pulses = 0;
    for (int c = 0; c < 60; c++) begin
      raw_exit     = (c < 40);
      raw_exit_loc = 2'b01;
      tick();
      vectors++;
      if (act !== exp_vec()) begin
        miscompares++;
        $display("FAIL stuck cycle %0d: dut=%b model=%b", c, act, exp_vec());
      end
      if (exit_fault && rise < 0) rise = c;
      if (!exit_fault && rise >= 0 && fall < 0) fall = c;
      if (exit_sensor) pulses++;
    end
    vectors++;
    if (rise != 21 || fall != 45 || pulses != 0) begin
      miscompares++;
      $display("FAIL stuck_fault: rise=%0d fall=%0d pulses=%0d required 21/45/0", rise, fall, pulses);
    end
  endtask

  task automatic test_reset_mid_pass();
    int pulses;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      raw_entry = 1'b1;
      tick();
      vectors++;
      if (act !== exp_vec()) begin
        miscompares++;
        $display("FAIL mid_pass_pre cycle %0d: dut=%b model=%b", c, act, exp_vec());
      end
    end
    reset = 1'b1;
    model_clear();
    #1;
    vectors++;
    if (act !== 6'b0) begin
      miscompares++;
      $display("FAIL mid_pass_async: dut=%b required=%b", act, 6'b0);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if (act !== 6'b0) begin
        miscompares++;
        $display("FAIL mid_pass_reset cycle %0d: dut=%b required=%b", c, act, 6'b0);
      end
    end
    raw_entry = 1'b0;
    reset = 1'b0;
    for (int c = 0; c < 25; c++) begin
      tick();
      vectors++;
      if (act !== exp_vec()) begin
        miscompares++;
        $display("FAIL mid_pass_post cycle %0d: dut=%b model=%b", c, act, exp_vec());
      end
      if (entry_sensor) pulses++;
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL mid_pass_discard: pulses=%0d required 0", pulses);
    end
  endtask

  task automatic test_back_to_back();
    int e_left, x_left, seen, base;
    e_left = 0; x_left = $urandom_range(0, 3); seen = 0;
    base = exp_entry_total;
    for (int c = 0; c < 240; c++) begin
      if (c >= 220) begin
        raw_entry = 1'b0; raw_exit = 1'b0;
      end else begin
        if (e_left == 0) begin raw_entry = ~raw_entry; e_left = $urandom_range(4, 7); end
        if (x_left == 0) begin
          raw_exit = ~raw_exit; x_left = $urandom_range(4, 7);
          if (raw_exit) raw_exit_loc = 2'($urandom_range(0, 3));
        end
        e_left--; x_left--;
      end
      tick();
      vectors++;
      if (act !== exp_vec()) begin
        miscompares++;
        $display("FAIL back_to_back cycle %0d: dut=%b model=%b", c, act, exp_vec());
      end
      if (entry_sensor) seen++;
    end
    vectors++;
    if (seen != exp_entry_total - base || seen == 0) begin
      miscompares++;
      $display("FAIL back_to_back_count: entry pulses=%0d required %0d (nonzero)", seen, exp_entry_total - base);
    end
  endtask

  task automatic test_random();
    int e_left, x_left;
    e_left = 0; x_left = 0;
    for (int c = 0; c < 900; c++) begin
      if (c == 450) begin
        reset = 1'b1;
        model_clear();
      end
      if (c == 452) reset = 1'b0;
      if (c >= 880) begin
        raw_entry = 1'b0; raw_exit = 1'b0;
      end else begin
        if (e_left == 0) begin
          raw_entry = ~raw_entry;
          e_left = (raw_entry && $urandom_range(0, 7) == 0) ? $urandom_range(18, 30) : $urandom_range(1, 12);
        end
        if (x_left == 0) begin
          raw_exit = ~raw_exit;
          x_left = (raw_exit && $urandom_range(0, 7) == 0) ? $urandom_range(18, 30) : $urandom_range(1, 12);
          if (raw_exit) raw_exit_loc = 2'($urandom_range(0, 3));
        end
        e_left--; x_left--;
      end
      tick();
      vectors++;
      if (act !== exp_vec()) begin
        miscompares++;
        $display("FAIL random cycle %0d: dut=%b model=%b", c, act, exp_vec());
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    raw_entry = 1'b0;
    raw_exit = 1'b0;
    raw_exit_loc = 2'b00;
    exp_entry_total = 0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_clean_entry();
    test_glitch();
    test_exit_loc();
    test_simultaneous();
    test_stuck();
    test_reset_mid_pass();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
